// File: rtl/mc_arb_pkg.sv
// rtl/mc_arb_pkg.sv - shared constants for the MC request arbiter
// Purpose: command encodings and field widths used by mc_req_arb and its bench.
// Ports: none (package).
package mc_arb_pkg;
    localparam logic [2:0] CMD_RD    = 3'd1;
    localparam logic [2:0] CMD_WR    = 3'd2;
    localparam int         PORT_ID_W = 8;
    localparam int         VADR_W    = 48;
    localparam int         DATA_W    = 64;
    localparam int         RDCTL_W   = 24;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - N-wide round-robin priority encoder
// Purpose: first set bit of req scanning upward from start, wrapping at N.
// Ports:
//   req    in   N    request mask
//   start  in   IW   scan start index (must be < N)
//   gnt    out  N    one-hot grant
//   idx    out  IW   index of the granted bit
//   any    out  1    at least one request present
module rr_pick #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    int p;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        p   = 0;
        for (int k = 0; k < N; k++) begin
            p = int'(start) + k;
            if (p >= N) p = p - N;
            if (!any && req[p]) begin
                any    = 1'b1;
                gnt[p] = 1'b1;
                idx    = IW'(p);
            end
        end
    end
endmodule

// File: rtl/mc_req_arb.sv
// rtl/mc_req_arb.sv - round-robin MC request arbiter with burst and read credits
// Purpose: shares one MC request port among NPORT requesters; stamps the port id
// into rtnctl[31:24] so the response xbar can route read data back.
// Ports:
//   clk167, reset167            clock, synchronous active-high reset
//   req_vld/cmd/vadr/data/rdctl per-port requests, held until req_ack
//   req_ack                     one-hot accept pulse
//   mc_rq_stall                 MC backpressure
//   mc_rq_vld/cmd/vadr/data/rtnctl  registered MC request
//   rsp_ret                     per-port read response consumed
//   idle, err_undflow           status
module mc_req_arb
    import mc_arb_pkg::*;
#(
    parameter int NPORT     = 8,
    parameter int MAX_BURST = 4,
    parameter int MAX_OUTST = 8
) (
    input  logic                   clk167,
    input  logic                   reset167,
    input  logic [NPORT-1:0]       req_vld,
    input  logic [3*NPORT-1:0]     req_cmd,
    input  logic [48*NPORT-1:0]    req_vadr,
    input  logic [64*NPORT-1:0]    req_data,
    input  logic [24*NPORT-1:0]    req_rdctl,
    output logic [NPORT-1:0]       req_ack,
    input  logic                   mc_rq_stall,
    output logic                   mc_rq_vld,
    output logic [2:0]             mc_rq_cmd,
    output logic [VADR_W-1:0]      mc_rq_vadr,
    output logic [DATA_W-1:0]      mc_rq_data,
    output logic [31:0]            mc_rq_rtnctl,
    input  logic [NPORT-1:0]       rsp_ret,
    output logic                   idle,
    output logic                   err_undflow
);
    localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    logic [IW-1:0]        rr_ptr;      // next scan start = last winner + 1
    logic [IW-1:0]        owner;
    logic                 owner_vld;
    logic [BW-1:0]        burst_cnt;
    logic [OW-1:0]        outst [NPORT];

    logic [NPORT-1:0]     eligible;
    logic [NPORT-1:0]     pick_gnt;
    logic [NPORT-1:0]     rd_inc;
    logic [IW-1:0]        pick_idx;
    logic [IW-1:0]        win_idx;
    logic                 pick_any;
    logic                 owner_ok;
    logic                 issue;
    logic                 any_outst;
    logic [2:0]           win_cmd;
    logic [VADR_W-1:0]    win_vadr;
    logic [DATA_W-1:0]    win_data;
    logic [RDCTL_W-1:0]   win_rdctl;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NPORT; i++) begin
            eligible[i] = req_vld[i] &
                          ((req_cmd[3*i +: 3] != CMD_RD) | (outst[i] < OW'(MAX_OUTST)));
        end
    end

    rr_pick #(.N(NPORT), .IW(IW)) u_pick (
        .req   (eligible),
        .start (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // The burst owner keeps the grant while it stays eligible and has budget left;
    // otherwise the round-robin scan decides.
    assign owner_ok = owner_vld & eligible[owner] & (burst_cnt < BW'(MAX_BURST));
    assign issue    = ~reset167 & ~mc_rq_stall & pick_any;
    assign win_idx  = owner_ok ? owner : pick_idx;
    assign req_ack  = issue ? (owner_ok ? (NPORT'(1) << owner) : pick_gnt) : '0;

    always_comb begin
        win_cmd   = '0;
        win_vadr  = '0;
        win_data  = '0;
        win_rdctl = '0;
        rd_inc    = '0;
        any_outst = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            if (win_idx == IW'(i)) begin
                win_cmd   = req_cmd[3*i +: 3];
                win_vadr  = req_vadr[48*i +: 48];
                win_data  = req_data[64*i +: 64];
                win_rdctl = req_rdctl[24*i +: 24];
            end
            if (outst[i] != '0) any_outst = 1'b1;
        end
        for (int i = 0; i < NPORT; i++) begin
            rd_inc[i] = issue & (win_idx == IW'(i)) & (win_cmd == CMD_RD);
        end
    end

    assign idle = ~any_outst & ~mc_rq_vld;

    always_ff @(posedge clk167) begin
        if (reset167) begin
            rr_ptr       <= '0;
            owner        <= '0;
            owner_vld    <= 1'b0;
            burst_cnt    <= '0;
            mc_rq_vld    <= 1'b0;
            mc_rq_cmd    <= '0;
            mc_rq_vadr   <= '0;
            mc_rq_data   <= '0;
            mc_rq_rtnctl <= '0;
            err_undflow  <= 1'b0;
            for (int i = 0; i < NPORT; i++) outst[i] <= '0;
        end else begin
            mc_rq_vld <= issue;
            if (issue) begin
                mc_rq_cmd    <= win_cmd;
                mc_rq_vadr   <= win_vadr;
                mc_rq_data   <= win_data;
                mc_rq_rtnctl <= {PORT_ID_W'(win_idx), win_rdctl};
                rr_ptr       <= (win_idx == IW'(NPORT - 1)) ? '0 : win_idx + IW'(1);
                if (owner_ok) begin
                    burst_cnt <= burst_cnt + BW'(1);
                end else begin
                    owner     <= win_idx;
                    owner_vld <= 1'b1;
                    burst_cnt <= BW'(1);
                end
            end
            // Issue and return on the same port in one cycle cancel out.
            for (int i = 0; i < NPORT; i++) begin
                if (rd_inc[i] && !rsp_ret[i]) begin
                    outst[i] <= outst[i] + OW'(1);
                end else if (!rd_inc[i] && rsp_ret[i]) begin
                    if (outst[i] == '0) err_undflow <= 1'b1;
                    else                outst[i] <= outst[i] - OW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mc_req_arb.sv
// tb/tb_mc_req_arb.sv - randomized self-checking bench for mc_req_arb
module tb_mc_req_arb;
    import mc_arb_pkg::*;

    localparam int NP = 8;
    localparam int MB = 4;
    localparam int MO = 4;

    logic              clk167 = 1'b0;
    logic              reset167;
    logic [NP-1:0]     req_vld;
    logic [3*NP-1:0]   req_cmd;
    logic [48*NP-1:0]  req_vadr;
    logic [64*NP-1:0]  req_data;
    logic [24*NP-1:0]  req_rdctl;
    logic [NP-1:0]     req_ack;
    logic              mc_rq_stall;
    logic              mc_rq_vld;
    logic [2:0]        mc_rq_cmd;
    logic [47:0]       mc_rq_vadr;
    logic [63:0]       mc_rq_data;
    logic [31:0]       mc_rq_rtnctl;
    logic [NP-1:0]     rsp_ret;
    logic              idle;
    logic              err_undflow;

    mc_req_arb #(.NPORT(NP), .MAX_BURST(MB), .MAX_OUTST(MO)) dut (
        .clk167(clk167), .reset167(reset167),
        .req_vld(req_vld), .req_cmd(req_cmd), .req_vadr(req_vadr),
        .req_data(req_data), .req_rdctl(req_rdctl), .req_ack(req_ack),
        .mc_rq_stall(mc_rq_stall), .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd),
        .mc_rq_vadr(mc_rq_vadr), .mc_rq_data(mc_rq_data), .mc_rq_rtnctl(mc_rq_rtnctl),
        .rsp_ret(rsp_ret), .idle(idle), .err_undflow(err_undflow)
    );

    always #5 clk167 = ~clk167;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // requester state
    logic        pend [NP];
    logic [2:0]  pc [NP];
    logic [47:0] pa [NP];
    logic [63:0] pd [NP];
    logic [23:0] pr [NP];

    // reference model state
    int   m_out [NP];
    int   m_ptr, m_owner, m_burst;
    bit   m_err;
    bit   exp_vld;
    logic [2:0]  exp_cmd;
    logic [47:0] exp_vadr;
    logic [63:0] exp_data;
    logic [31:0] exp_rtn;

    // stimulus knobs
    logic [NP-1:0] gen_mask;
    logic [NP-1:0] force_rsp;
    int   p_new, p_stall, cmd_mode;
    bit   rsp_en, force_stall;

    int   ack_cnt [NP];
    int   ack_q [$];

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_out[p] = 0; pend[p] = 1'b0; ack_cnt[p] = 0;
        end
        m_ptr = 0; m_owner = -1; m_burst = 0; m_err = 0; exp_vld = 0;
    endtask

    task automatic do_reset();
        @(negedge clk167);
        reset167    = 1'b1;
        req_vld     = '1;
        req_cmd     = {NP{CMD_RD}};
        mc_rq_stall = 1'b0;
        rsp_ret     = '0;
        #1;
        chk("rst_ack", req_ack, '0);
        @(negedge clk167);
        chk("rst_ack2", req_ack, '0);
        chk("rst_vld", mc_rq_vld, 0);
        chk("rst_idle", idle, 1);
        chk("rst_err", err_undflow, 0);
        req_vld  = '0;
        reset167 = 1'b0;
        model_reset();
    endtask

    task automatic step();
        logic [NP-1:0] exp_ack;
        bit   m_elig [NP];
        bit   any_elig;
        bit   all_zero;
        int   m_win;
        int   p;

        @(negedge clk167);
        chk("mc_rq_vld", mc_rq_vld, exp_vld);
        if (exp_vld) begin
            chk("mc_rq_cmd", mc_rq_cmd, exp_cmd);
            chk("mc_rq_vadr", mc_rq_vadr, exp_vadr);
            chk("mc_rq_data", mc_rq_data, exp_data);
            chk("mc_rq_rtnctl", mc_rq_rtnctl, exp_rtn);
        end
        all_zero = 1;
        for (int i = 0; i < NP; i++) if (m_out[i] != 0) all_zero = 0;
        chk("idle", idle, all_zero && !exp_vld);
        chk("err_undflow", err_undflow, m_err);

        for (int i = 0; i < NP; i++) begin
            if (!pend[i] && gen_mask[i] && ($urandom_range(99) < p_new)) begin
                pend[i] = 1'b1;
                pc[i] = (cmd_mode == 1) ? CMD_WR : (cmd_mode == 2) ? CMD_RD :
                        ($urandom_range(1) != 0 ? CMD_RD : CMD_WR);
                pa[i] = {$urandom(), $urandom()};
                pd[i] = {$urandom(), $urandom()};
                pr[i] = 24'($urandom());
            end
            req_vld[i]         = pend[i];
            req_cmd[3*i +: 3]  = pc[i];
            req_vadr[48*i +: 48] = pa[i];
            req_data[64*i +: 64] = pd[i];
            req_rdctl[24*i +: 24] = pr[i];
            rsp_ret[i] = force_rsp[i] ||
                         (rsp_en && m_out[i] > 0 && $urandom_range(2) == 0);
        end
        mc_rq_stall = force_stall || ($urandom_range(99) < p_stall);
        #1;

        any_elig = 0;
        for (int i = 0; i < NP; i++) begin
            m_elig[i] = pend[i] && (pc[i] != CMD_RD || m_out[i] < MO);
            if (m_elig[i]) any_elig = 1;
        end
        m_win = -1;
        if (!mc_rq_stall && any_elig) begin
            if (m_owner >= 0 && m_elig[m_owner] && m_burst < MB) begin
                m_win = m_owner;
                m_burst++;
            end else begin
                for (int k = 0; k < NP; k++) begin
                    p = (m_ptr + k) % NP;
                    if (m_win < 0 && m_elig[p]) m_win = p;
                end
                m_owner = m_win;
                m_burst = 1;
            end
            m_ptr = (m_win + 1) % NP;
        end
        exp_ack = '0;
        if (m_win >= 0) exp_ack[m_win] = 1'b1;
        chk("req_ack", req_ack, exp_ack);

        for (int i = 0; i < NP; i++) begin
            if (req_ack[i]) begin
                ack_cnt[i]++;
                ack_q.push_back(i);
            end
        end

        exp_vld = (m_win >= 0);
        if (m_win >= 0) begin
            exp_cmd  = pc[m_win];
            exp_vadr = pa[m_win];
            exp_data = pd[m_win];
            exp_rtn  = {8'(m_win), pr[m_win]};
            if (pc[m_win] == CMD_RD) m_out[m_win]++;
            pend[m_win] = 1'b0;
        end
        for (int i = 0; i < NP; i++) begin
            if (rsp_ret[i]) begin
                if (m_out[i] > 0) m_out[i]--;
                else              m_err = 1;
            end
        end
        force_rsp = '0;
    endtask

    initial begin
        int drained;
        int exp_seq [9];
        exp_seq = '{2, 2, 2, 2, 5, 5, 5, 5, 2};
        reset167 = 1'b1; req_vld = '0; req_cmd = '0; req_vadr = '0; req_data = '0;
        req_rdctl = '0; mc_rq_stall = 1'b0; rsp_ret = '0;
        gen_mask = '0; force_rsp = '0; p_new = 0; p_stall = 0; cmd_mode = 0;
        rsp_en = 0; force_stall = 0;
        model_reset();
        repeat (2) @(posedge clk167);

        // reset with all ports requesting
        do_reset();

        // ports 2 and 5 streaming writes: burst of MAX_BURST then rotate
        gen_mask = 8'b0010_0100; p_new = 100; cmd_mode = 1;
        ack_q.delete();
        repeat (10) step();
        for (int i = 0; i < 9; i++)
            chk($sformatf("burst_seq%0d", i), (i < ack_q.size()) ? ack_q[i] : -1, exp_seq[i]);

        // port 3 stream with a 3-cycle stall in the middle
        do_reset();
        gen_mask = 8'b0000_1000; cmd_mode = 1;
        repeat (6) step();
        force_stall = 1;
        repeat (3) step();
        force_stall = 0;
        repeat (6) step();
        chk("stall_acks", ack_cnt[3], 12);

        // read credit limit on port 0
        do_reset();
        gen_mask = 8'b0000_0001; cmd_mode = 2;
        repeat (10) step();
        chk("credit_cap", ack_cnt[0], MO);
        force_rsp = 8'b0000_0001;
        repeat (5) step();
        chk("credit_ret", ack_cnt[0], MO + 1);

        // randomized mixed traffic
        do_reset();
        gen_mask = '1; p_new = 50; p_stall = 20; cmd_mode = 0; rsp_en = 1;
        repeat (800) step();

        // drain, then provoke underflow on port 6
        gen_mask = '0; p_stall = 0;
        drained = 0;
        for (int n = 0; n < 300 && !drained; n++) begin
            step();
            drained = 1;
            for (int i = 0; i < NP; i++) if (m_out[i] != 0 || pend[i]) drained = 0;
        end
        chk("drained", drained, 1);
        rsp_en = 0;
        repeat (2) step();
        force_rsp = 8'b0100_0000;
        step();
        repeat (4) step();
        chk("err_sticky", err_undflow, 1);
        do_reset();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
